handshake_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one terminal-side valid/ready sink between N_SRC source channels.
- Each source presents valid/data. The arbiter grants one source at a time for a bounded burst and forwards the granted channel's handshake to the single output.
- Sits between several source instances and one terminal instance inside the handshake top level.

---
 rtl/handshake_rr_arbiter_pkg.sv | 21 ++
 rtl/handshake_rr_arbiter_rr_pick.sv | 32 +++
 rtl/handshake_rr_arbiter.sv | 117 +++++++++++
 tb/tb_handshake_rr_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : handshake_rr_arbiter_pkg
// Brief  : Shared state encodings and default sizing for the RR arbiter.
// Rev    : 1.0
// ============================================================================
package handshake_rr_arbiter_pkg;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

    localparam int DEF_N_SRC     = 4;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_MAX_BURST = 8;
    localparam int DEF_IDX_W     = 2;

    // Wide enough for MAX_BURST up to 255.
    localparam int BEAT_CNT_W = 8;

endpackage : handshake_rr_arbiter_pkg
`default_nettype wire

// File: rtl/handshake_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Rotating-priority encoder; first set req bit at or above ptr, wrapping.
// Rev    : 1.0
// ============================================================================
module rr_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Constant bit selects keep the index width-exact for any N_SRC.
        for (int k = 0; k < N_SRC; k++) begin
            for (int j = 0; j < N_SRC; j++) begin
                if (!any && req[j] && (j == ((int'(ptr) + k) % N_SRC))) begin
                    idx = IDX_W'(j);
                    any = 1'b1;
                end
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/handshake_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : handshake_rr_arbiter
// Brief  : Round-robin burst arbiter sharing one valid/ready sink among N_SRC sources.
// Rev    : 1.0
// ============================================================================
module handshake_rr_arbiter
    import handshake_rr_arbiter_pkg::*;
#(
    parameter int N_SRC     = DEF_N_SRC,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_SRC-1:0]       in_valid,
    input  logic [N_SRC*WIDTH-1:0] in_data,
    output logic [N_SRC-1:0]       in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_src,
    output logic                   grant_active
);

    localparam logic [BEAT_CNT_W-1:0] c_last_beat = BEAT_CNT_W'(MAX_BURST - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [IDX_W-1:0]      r_grant;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;

    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_any;
    logic                  w_gvalid;
    logic [WIDTH-1:0]      w_gdata;
    logic                  w_beat;
    logic                  w_release;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (in_valid),
        .ptr (r_rr_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_gvalid  = in_valid[r_grant];
    assign w_beat    = (r_state == ARB_GRANT) && w_gvalid && out_ready;
    // Burst limit and source drain may coincide; either alone releases once.
    assign w_release = (r_state == ARB_GRANT) &&
                       (!w_gvalid || (w_beat && (r_beat_cnt == c_last_beat)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_pick_any) w_state_nxt = ARB_GRANT;
            ARB_GRANT: if (w_release)  w_state_nxt = ARB_IDLE;
            default:   w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == ARB_IDLE) begin
            if (w_pick_any) begin
                r_grant    <= w_pick_idx;
                r_beat_cnt <= '0;
            end
        end else if (w_release) begin
            r_rr_ptr <= (r_grant == IDX_W'(N_SRC - 1)) ? '0 : r_grant + 1'b1;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    always_comb begin
        in_ready     = '0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_src      = '0;
        grant_active = 1'b0;
        if (r_state == ARB_GRANT) begin
            grant_active      = 1'b1;
            out_src           = r_grant;
            out_valid         = w_gvalid;
            out_data          = w_gvalid ? w_gdata : '0;
            in_ready[r_grant] = out_ready;
        end
    end

endmodule : handshake_rr_arbiter
`default_nettype wire

// File: tb/tb_handshake_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_handshake_rr_arbiter
// Brief  : Vector table plus scoreboarded burst sequences for the RR arbiter.
// Rev    : 1.0
// ============================================================================
module tb_handshake_rr_arbiter;

    localparam int N_SRC = 4;
    localparam int WIDTH = 32;
    localparam int IDX_W = 2;

    logic                   clk;
    logic                   rstn;
    logic [N_SRC-1:0]       in_valid;
    logic [N_SRC*WIDTH-1:0] in_data;
    logic [N_SRC-1:0]       in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_ready;
    logic [IDX_W-1:0]       out_src;
    logic                   grant_active;

    handshake_rr_arbiter #(
        .N_SRC     (N_SRC),
        .WIDTH     (WIDTH),
        .MAX_BURST (8),
        .IDX_W     (IDX_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .out_src      (out_src),
        .grant_active (grant_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] iv;
        logic       ordy;
        logic       ov;
        logic       ga;
        logic [1:0] src;
        logic [3:0] ird;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  src;
    } beat_t;

    vec_t        tbl [21];
    logic [31:0] src_q [N_SRC][$];
    beat_t       exp_q [$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] chan_data(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Sources pop on accepted beats; every beat is compared against the queue.
    task automatic run_seq(input string name, input int budget, input int exp_idle);
        int               cyc;
        int               idle;
        beat_t            e;
        logic [N_SRC-1:0] v_snap;
        logic [N_SRC-1:0] r_snap;
        cyc  = 0;
        idle = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            for (int i = 0; i < N_SRC; i++) begin
                in_valid[i]             = (src_q[i].size() > 0);
                in_data[i*WIDTH +: WIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : 32'h0;
            end
            out_ready = 1'b1;
            #1;
            if (!grant_active && in_valid != '0) idle++;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check({name, "_data"}, 64'(out_data), 64'(e.data));
                check({name, "_src"},  64'(out_src),  64'(e.src));
            end
            v_snap = in_valid;
            r_snap = in_ready;
            @(posedge clk);
            for (int i = 0; i < N_SRC; i++) begin
                if (v_snap[i] && r_snap[i]) void'(src_q[i].pop_front());
            end
            cyc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d beats left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_idle_bubbles"}, 64'(idle), 64'(exp_idle));
        @(negedge clk);
        in_valid = '0;
        for (int i = 0; i < N_SRC; i++) src_q[i].delete();
    endtask

    initial begin
        // {in_valid, out_ready, exp out_valid, grant_active, out_src, in_ready}
        tbl[0]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[2]  = '{4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000};
        tbl[3]  = '{4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000};
        tbl[4]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100};
        tbl[6]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[7]  = '{4'b0110, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[8]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010};
        tbl[9]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[10] = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[11] = '{4'b1000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100};
        tbl[12] = '{4'b1001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[13] = '{4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[14] = '{4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[15] = '{4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[16] = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000};
        tbl[17] = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[18] = '{4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[19] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000};
        tbl[20] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};

        rstn      = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < N_SRC; i++) in_data[i*WIDTH +: WIDTH] = chan_data(i);
        #3;
        check("rst_grant_active", 64'(grant_active), 64'd0);
        check("rst_out_valid",    64'(out_valid),    64'd0);
        check("rst_out_data",     64'(out_data),     64'd0);
        check("rst_out_src",      64'(out_src),      64'd0);
        check("rst_in_ready",     64'(in_ready),     64'd0);
        do_reset();

        // Backpressure on src2, wrap from ptr 3 to src1, early release of src3.
        for (int r = 0; r < 21; r++) begin
            @(negedge clk);
            in_valid  = tbl[r].iv;
            out_ready = tbl[r].ordy;
            #1;
            check($sformatf("vec%0d_out_valid", r), 64'(out_valid), 64'(tbl[r].ov));
            check($sformatf("vec%0d_grant_active", r), 64'(grant_active), 64'(tbl[r].ga));
            check($sformatf("vec%0d_out_src", r), 64'(out_src), 64'(tbl[r].src));
            check($sformatf("vec%0d_in_ready", r), 64'(in_ready), 64'(tbl[r].ird));
            check($sformatf("vec%0d_out_data", r), 64'(out_data),
                  tbl[r].ov ? 64'(chan_data(int'(tbl[r].src))) : 64'd0);
        end

        // Single source: 8-beat burst, bubble, re-grant for last 2 beats.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            src_q[1].push_back(32'hA5A5_0000 | 32'(k));
            exp_q.push_back('{32'hA5A5_0000 | 32'(k), 2'd1});
        end
        run_seq("single", 60, 2);

        // All four continuously valid: rotation 0,1,2,3,0,1,2,3, 8 beats each.
        do_reset();
        for (int s = 0; s < N_SRC; s++) begin
            for (int k = 0; k < 16; k++) src_q[s].push_back({8'hB0 + 8'(s), 24'(k)});
        end
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int s = 0; s < N_SRC; s++) begin
                for (int k = 0; k < 8; k++) exp_q.push_back('{{8'hB0 + 8'(s), 24'(rnd*8 + k)}, 2'(s)});
            end
        end
        run_seq("rotate", 200, 8);

        // Async reset mid-burst: grant=2, beat_cnt=3.
        do_reset();
        @(negedge clk);
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        for (int i = 0; i < N_SRC; i++) in_data[i*WIDTH +: WIDTH] = chan_data(i);
        repeat (4) @(negedge clk);
        #2;
        check("pre_rst_src", 64'(out_src), 64'd2);
        rstn = 1'b0;
        #1;
        check("midrst_grant_active", 64'(grant_active), 64'd0);
        check("midrst_out_valid",    64'(out_valid),    64'd0);
        check("midrst_out_data",     64'(out_data),     64'd0);
        check("midrst_in_ready",     64'(in_ready),     64'd0);
        @(negedge clk);
        rstn     = 1'b1;
        in_valid = 4'b0101;
        @(negedge clk);
        #1;
        check("postrst_out_src",   64'(out_src),   64'd0);
        check("postrst_out_valid", 64'(out_valid), 64'd1);
        check("postrst_out_data",  64'(out_data),  64'(chan_data(0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_handshake_rr_arbiter
`default_nettype wire
